// File: rtl/actuator_sequencer.sv
// Drives doors, beeping buzzers and min-on/min-off protected heater/cooler
// from the registered 3-bit action code A. All outputs are registered.
module actuator_sequencer #(
  parameter int unsigned DOOR_HOLD = 16,
  parameter int unsigned BEEP_HALF = 8,
  parameter int unsigned MIN_ON    = 32,
  parameter int unsigned MIN_OFF   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] A,
  output logic       front_door,
  output logic       rear_door,
  output logic       alarm_buzzer,
  output logic       window_buzzer,
  output logic       heater,
  output logic       cooler,
  output logic [1:0] climate_state,
  output logic       idle
);

  localparam int unsigned DW = $clog2(DOOR_HOLD + 1);
  localparam int unsigned BW = $clog2(BEEP_HALF + 1);
  localparam int unsigned OW = $clog2(MIN_ON + 1);
  localparam int unsigned FW = $clog2(MIN_OFF + 1);

  localparam logic [DW-1:0] DOOR_RELOAD = DW'(DOOR_HOLD - 1);
  localparam logic [BW-1:0] BH          = BW'(BEEP_HALF);
  localparam logic [OW-1:0] MON         = OW'(MIN_ON);
  localparam logic [FW-1:0] MOFF        = FW'(MIN_OFF);

  typedef enum logic [1:0] {CL_OFF = 2'd0, CL_HEAT = 2'd1, CL_COOL = 2'd2, CL_REST = 2'd3} climate_t;
  typedef enum logic [1:0] {BZ_NONE = 2'd0, BZ_ALARM = 2'd1, BZ_WINDOW = 2'd2} buzz_t;

  logic          r_front, r_rear, r_alarm, r_window, r_heater, r_cooler, r_idle;
  logic [DW-1:0] r_door_cnt;
  buzz_t         r_buzz_sel;
  logic          r_beep_lvl;
  logic [BW-1:0] r_beep_cnt;
  climate_t      r_state;
  logic [OW-1:0] r_on_cnt;
  logic [FW-1:0] r_off_cnt;

  logic          w_front, w_rear, w_alarm, w_window, w_heater, w_cooler, w_idle;
  logic [DW-1:0] w_door_cnt;
  buzz_t         w_buzz_sel;
  logic          w_beep_lvl;
  logic [BW-1:0] w_beep_cnt;
  climate_t      w_state;
  logic [OW-1:0] w_on_cnt;
  logic [FW-1:0] w_off_cnt;

  always_comb begin
    w_front    = r_front;
    w_rear     = r_rear;
    w_door_cnt = r_door_cnt;
    w_buzz_sel = r_buzz_sel;
    w_beep_lvl = r_beep_lvl;
    w_beep_cnt = r_beep_cnt;
    w_state    = r_state;
    w_on_cnt   = r_on_cnt;
    w_off_cnt  = r_off_cnt;

    // Door timer holds remaining cycles after the current one; door drops when it is already 0.
    if (A == 3'd1) begin
      w_front    = 1'b1;
      w_rear     = 1'b0;
      w_door_cnt = DOOR_RELOAD;
    end else if (A == 3'd2) begin
      w_front    = 1'b0;
      w_rear     = 1'b1;
      w_door_cnt = DOOR_RELOAD;
    end else if (r_door_cnt != '0) begin
      w_door_cnt = r_door_cnt - 1'b1;
    end else begin
      w_front = 1'b0;
      w_rear  = 1'b0;
    end

    if (A == 3'd3 || A == 3'd4) begin
      w_buzz_sel = (A == 3'd3) ? BZ_ALARM : BZ_WINDOW;
      if (w_buzz_sel != r_buzz_sel) begin
        w_beep_lvl = 1'b1;
        w_beep_cnt = BW'(1);
      end else if (r_beep_cnt >= BH) begin
        w_beep_lvl = ~r_beep_lvl;
        w_beep_cnt = BW'(1);
      end else begin
        w_beep_cnt = r_beep_cnt + 1'b1;
      end
    end else begin
      w_buzz_sel = BZ_NONE;
      w_beep_lvl = 1'b0;
      w_beep_cnt = '0;
    end
    w_alarm  = (w_buzz_sel == BZ_ALARM)  && w_beep_lvl;
    w_window = (w_buzz_sel == BZ_WINDOW) && w_beep_lvl;

    case (r_state)
      CL_OFF: begin
        if (A == 3'd5) begin
          w_state  = CL_HEAT;
          w_on_cnt = OW'(1);
        end else if (A == 3'd6) begin
          w_state  = CL_COOL;
          w_on_cnt = OW'(1);
        end
      end
      CL_HEAT, CL_COOL: begin
        if ((A != ((r_state == CL_HEAT) ? 3'd5 : 3'd6)) && (r_on_cnt >= MON)) begin
          w_state   = CL_REST;
          w_off_cnt = FW'(1);
        end else if (r_on_cnt < MON) begin
          w_on_cnt = r_on_cnt + 1'b1;
        end
      end
      default: begin
        if (r_off_cnt < MOFF) begin
          w_off_cnt = r_off_cnt + 1'b1;
        end else if (A == 3'd5) begin
          w_state  = CL_HEAT;
          w_on_cnt = OW'(1);
        end else if (A == 3'd6) begin
          w_state  = CL_COOL;
          w_on_cnt = OW'(1);
        end else begin
          w_state = CL_OFF;
        end
      end
    endcase
    w_heater = (w_state == CL_HEAT);
    w_cooler = (w_state == CL_COOL);

    w_idle = !(w_front || w_rear || w_alarm || w_window || w_heater || w_cooler)
             && (w_state == CL_OFF);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_front    <= 1'b0;
      r_rear     <= 1'b0;
      r_door_cnt <= '0;
      r_buzz_sel <= BZ_NONE;
      r_beep_lvl <= 1'b0;
      r_beep_cnt <= '0;
      r_alarm    <= 1'b0;
      r_window   <= 1'b0;
      r_state    <= CL_OFF;
      r_on_cnt   <= '0;
      r_off_cnt  <= '0;
      r_heater   <= 1'b0;
      r_cooler   <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_front    <= w_front;
      r_rear     <= w_rear;
      r_door_cnt <= w_door_cnt;
      r_buzz_sel <= w_buzz_sel;
      r_beep_lvl <= w_beep_lvl;
      r_beep_cnt <= w_beep_cnt;
      r_alarm    <= w_alarm;
      r_window   <= w_window;
      r_state    <= w_state;
      r_on_cnt   <= w_on_cnt;
      r_off_cnt  <= w_off_cnt;
      r_heater   <= w_heater;
      r_cooler   <= w_cooler;
      r_idle     <= w_idle;
    end
  end

  assign front_door    = r_front;
  assign rear_door     = r_rear;
  assign alarm_buzzer  = r_alarm;
  assign window_buzzer = r_window;
  assign heater        = r_heater;
  assign cooler        = r_cooler;
  assign climate_state = r_state;
  assign idle          = r_idle;

endmodule

// File: tb/tb_actuator_sequencer.sv
// Randomized and directed bench for actuator_sequencer against a time-based
// reference model (elapsed cycles since each request/state entry).
module tb_actuator_sequencer;

  localparam int DH   = 4;
  localparam int BH   = 2;
  localparam int MON  = 5;
  localparam int MOFF = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] A;
  logic       front_door, rear_door, alarm_buzzer, window_buzzer, heater, cooler, idle;
  logic [1:0] climate_state;

  int n_total = 0;
  int n_bad   = 0;

  // model state: edge index, last door request, buzzer run start, climate state entry
  int k;
  int m_door, m_door_t;
  int m_bz, m_bz_t;
  int m_cs, m_cs_t;

  actuator_sequencer #(
    .DOOR_HOLD(DH),
    .BEEP_HALF(BH),
    .MIN_ON(MON),
    .MIN_OFF(MOFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .A(A),
    .front_door(front_door),
    .rear_door(rear_door),
    .alarm_buzzer(alarm_buzzer),
    .window_buzzer(window_buzzer),
    .heater(heater),
    .cooler(cooler),
    .climate_state(climate_state),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_door = 0; m_door_t = 0; m_bz = 0; m_bz_t = 0; m_cs = 0; m_cs_t = 0;
  endtask

  task automatic model_edge(input int a);
    k++;
    if (a == 1 || a == 2) begin
      m_door = a;
      m_door_t = k;
    end
    if (a == 3 || a == 4) begin
      if (m_bz != a) begin
        m_bz = a;
        m_bz_t = k;
      end
    end else begin
      m_bz = 0;
    end
    case (m_cs)
      0: if (a == 5) begin m_cs = 1; m_cs_t = k; end
         else if (a == 6) begin m_cs = 2; m_cs_t = k; end
      1: if (a != 5 && k - m_cs_t >= MON) begin m_cs = 3; m_cs_t = k; end
      2: if (a != 6 && k - m_cs_t >= MON) begin m_cs = 3; m_cs_t = k; end
      default: if (k - m_cs_t >= MOFF) begin
        m_cs_t = k;
        if (a == 5) m_cs = 1;
        else if (a == 6) m_cs = 2;
        else m_cs = 0;
      end
    endcase
  endtask

  task automatic check_all();
    bit e_front, e_rear, e_alarm, e_window, e_heat, e_cool, e_idle, on_phase;
    e_front  = (m_door == 1) && (k - m_door_t < DH);
    e_rear   = (m_door == 2) && (k - m_door_t < DH);
    on_phase = (((k - m_bz_t) / BH) % 2) == 0;
    e_alarm  = (m_bz == 3) && on_phase;
    e_window = (m_bz == 4) && on_phase;
    e_heat   = (m_cs == 1);
    e_cool   = (m_cs == 2);
    e_idle   = !(e_front || e_rear || e_alarm || e_window || e_heat || e_cool) && (m_cs == 0);
    chk("front_door", front_door, e_front);
    chk("rear_door", rear_door, e_rear);
    chk("alarm_buzzer", alarm_buzzer, e_alarm);
    chk("window_buzzer", window_buzzer, e_window);
    chk("heater", heater, e_heat);
    chk("cooler", cooler, e_cool);
    chk("climate_state", climate_state, m_cs);
    chk("idle", idle, e_idle);
  endtask

  task automatic step(input int a);
    @(negedge clk);
    A = a[2:0];
    @(posedge clk);
    model_edge(a);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    A = 3'd0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt, lowc;
    bit seen_heat, seen_cool;
    logic [9:0] pat;
    logic [1:0] wpat;

    A = 3'd0;
    reset = 1'b1;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // 1: single-cycle front door request
    step(1);
    cnt = front_door;
    for (int i = 0; i < 6; i++) begin
      step(0);
      cnt += front_door;
    end
    chk("t1_front_len", cnt, DH);
    chk("t1_idle_back", idle, 1);

    // 2: front held 2, then rear for 1
    do_reset();
    step(1); step(1);
    step(2);
    chk("t2_front_drop", front_door, 0);
    cnt = rear_door;
    for (int i = 0; i < 6; i++) begin
      step(0);
      cnt += rear_door;
    end
    chk("t2_rear_len", cnt, DH);

    // 3: alarm pattern and 3->4 restart
    do_reset();
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      step(3);
      pat = {pat[8:0], alarm_buzzer};
    end
    chk("t3_alarm_pat", pat, 10'b1100110011);
    step(0);
    chk("t3_alarm_off", alarm_buzzer, 0);
    step(3); step(3); step(3);
    step(4);
    wpat[1] = window_buzzer;
    step(4);
    wpat[0] = window_buzzer;
    chk("t3_window_start", wpat, 2'b11);

    // 4: heater pulse, then cooler held
    do_reset();
    step(5);
    cnt = heater; lowc = 0; seen_cool = 0;
    for (int i = 0; i < 12; i++) begin
      step(6);
      cnt += heater;
      if (cooler) seen_cool = 1;
      if (!heater && !cooler && !seen_cool) lowc++;
    end
    chk("t4_heat_len", cnt, MON);
    chk("t4_rest_gap", lowc, MOFF);

    // 5: heater held 8, then cooler; never both
    do_reset();
    cnt = 0; lowc = 0; seen_heat = 0; seen_cool = 0;
    for (int i = 0; i < 8; i++) begin
      step(5);
      cnt += heater;
    end
    for (int i = 0; i < 8; i++) begin
      step(6);
      cnt += heater;
      if (heater && cooler) seen_heat = 1;
      if (cooler) seen_cool = 1;
      if (!heater && !cooler && !seen_cool) lowc++;
    end
    chk("t5_heat_len", cnt, 8);
    chk("t5_rest_gap", lowc, MOFF);
    chk("t5_overlap", seen_heat, 0);

    // randomized runs of held codes
    do_reset();
    for (int r = 0; r < 120; r++) begin
      int code, len;
      code = $urandom_range(0, 7);
      len  = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) step(code);
    end

    // 6: async reset mid-HEAT with door open and buzzer on
    do_reset();
    step(5); step(1); step(3);
    chk("t6_pre_heat", heater, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) step(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
